// File: rtl/tinyarch_pkg.sv
// Shared state encoding for the DMA-style transfer engines.
// Imported by mem_dma; carries no logic.
package tinyarch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

endpackage

// File: rtl/mem_dma.sv
// Single-port memory copy/fill engine: copy costs 2 cycles per word, fill 1 cycle per word, plus a DONE cycle.
// No backpressure: memory is assumed ready every cycle; abort cancels the current access and returns to IDLE.
module mem_dma
    import tinyarch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  fill_mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] remaining
);

    dma_state_t            r_state;
    dma_state_t            w_next;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_fill_mode;
    logic [DATA_WIDTH-1:0] r_fill_value;
    logic                  w_accept;

    // Abort wins over start even while idle, so a simultaneous pair launches nothing.
    assign w_accept  = (r_state == IDLE) && start && !abort;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign remaining = r_remaining;

    always_comb begin
        w_next    = r_state;
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (length == '0)   w_next = DONE;
                    else if (fill_mode) w_next = WRITE;
                    else                w_next = READ;
                end
            end
            READ: begin
                mem_addr = r_src;
                mem_read = 1'b1;
                w_next   = abort ? IDLE : WRITE;
            end
            WRITE: begin
                mem_addr  = r_dst;
                mem_write = !abort;
                mem_wdata = r_fill_mode ? r_fill_value : r_hold;
                if (abort)                                w_next = IDLE;
                else if (r_remaining == ADDR_WIDTH'(1))   w_next = DONE;
                else if (r_fill_mode)                     w_next = WRITE;
                else                                      w_next = READ;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_remaining  <= '0;
            r_hold       <= '0;
            r_fill_mode  <= 1'b0;
            r_fill_value <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_src        <= src_addr;
                r_dst        <= dst_addr;
                r_remaining  <= length;
                r_fill_mode  <= fill_mode;
                r_fill_value <= fill_value;
            end
            if ((r_state == READ) && !abort) begin
                r_hold <= mem_rdata;
            end
            // Pointers wrap naturally at the address width.
            if ((r_state == WRITE) && !abort) begin
                r_src       <= r_src + ADDR_WIDTH'(1);
                r_dst       <= r_dst + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a behavioural 256x8 memory and a bench-side preload port.
module tb_mem_dma;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       fill_mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic [7:0] fill_value;
    logic       abort;
    logic [7:0] mem_addr;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    logic [7:0] mem [0:255];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_wdata;

    int total;
    int bad;
    int excl;
    int cyc;
    int wr;
    int bsy;

    mem_dma #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .fill_mode  (fill_mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .abort      (abort),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write)  mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_addr]  <= tb_wdata;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_addr  = a;
        tb_wdata = d;
        tb_we    = 1'b1;
        step();
        tb_we    = 1'b0;
    endtask

    task automatic go(input logic fm, input logic [7:0] s, input logic [7:0] d,
                      input logic [7:0] n, input logic [7:0] fv);
        fill_mode  = fm;
        src_addr   = s;
        dst_addr   = d;
        length     = n;
        fill_value = fv;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the start edge; returns the cycle index of the done pulse.
    task automatic run(output int c, output int w, output int b);
        c = 1;
        w = 0;
        b = 0;
        while (done !== 1'b1 && c < 40) begin
            if (mem_write === 1'b1) w++;
            if (busy === 1'b1) b++;
            if (mem_read === 1'b1 && mem_write === 1'b1) excl++;
            step();
            c++;
        end
    endtask

    initial begin
        total = 0; bad = 0; excl = 0;
        rst_n = 1'b0; start = 1'b0; fill_mode = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
        tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rw", {mem_read, mem_write}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_remaining", remaining, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Copy 4 words 0x10 -> 0x40
        poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
        poke(8'h44, 8'hEE);
        go(1'b0, 8'h10, 8'h40, 8'd4, 8'h00);
        chk("copy_first_addr", mem_addr, 8'h10);
        chk("copy_first_read", mem_read, 1);
        run(cyc, wr, bsy);
        chk("copy_done_cycle", cyc, 9);
        chk("copy_writes", wr, 4);
        chk("copy_busy_cycles", bsy, 8);
        chk("copy_done_busy", busy, 1);
        chk("copy_remaining", remaining, 0);
        chk("copy_data", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hA1B2C3D4);
        chk("copy_no_overrun", mem[8'h44], 8'hEE);
        step();
        chk("copy_done_one_cycle", {busy, done}, 0);

        // Fill 3 words at 0x80
        poke(8'h83, 8'h33);
        go(1'b1, 8'h00, 8'h80, 8'd3, 8'h5A);
        run(cyc, wr, bsy);
        chk("fill_done_cycle", cyc, 4);
        chk("fill_writes", wr, 3);
        chk("fill_data", {mem[8'h80], mem[8'h81], mem[8'h82]}, 24'h5A5A5A);
        chk("fill_untouched", mem[8'h83], 8'h33);
        step();

        // Zero length
        go(1'b1, 8'h00, 8'h50, 8'd0, 8'hFF);
        run(cyc, wr, bsy);
        chk("zero_done_cycle", cyc, 1);
        chk("zero_writes", wr, 0);
        step();

        // Fill wrapping past 0xFF
        poke(8'h01, 8'h77);
        go(1'b1, 8'h00, 8'hFE, 8'd3, 8'hC3);
        run(cyc, wr, bsy);
        chk("wrap_done_cycle", cyc, 4);
        chk("wrap_data", {mem[8'hFE], mem[8'hFF], mem[8'h00]}, 24'hC3C3C3);
        chk("wrap_untouched", mem[8'h01], 8'h77);
        step();

        // Abort during the third WRITE of an 8-word copy
        poke(8'h62, 8'h99);
        go(1'b0, 8'h10, 8'h60, 8'd8, 8'h00);
        wr = 0;
        repeat (5) begin
            if (mem_write === 1'b1) wr++;
            chk("abort_no_done_early", done, 0);
            step();
        end
        abort = 1'b1;
        #1;
        chk("abort_state_write", mem_addr, 8'h62);
        chk("abort_write_suppressed", mem_write, 0);
        step();
        abort = 1'b0;
        chk("abort_idle", {busy, done}, 0);
        chk("abort_writes", wr, 2);
        chk("abort_remaining", remaining, 6);
        chk("abort_data", {mem[8'h60], mem[8'h61], mem[8'h62]}, 24'hA1B2_99);
        step();
        chk("abort_no_done_late", done, 0);

        // Abort and start together: start is dropped
        abort = 1'b1;
        go(1'b1, 8'h00, 8'hA0, 8'd2, 8'h11);
        abort = 1'b0;
        chk("abort_prio_busy", busy, 0);
        chk("abort_prio_remaining", remaining, 6);

        // Overlapping copy propagates the first word
        poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03);
        go(1'b0, 8'h20, 8'h21, 8'd2, 8'h00);
        run(cyc, wr, bsy);
        chk("overlap_done_cycle", cyc, 5);
        chk("overlap_data", {mem[8'h21], mem[8'h22]}, 16'h0101);
        step();

        // Reset during the second READ
        poke(8'h71, 8'h55);
        go(1'b0, 8'h10, 8'h70, 8'd4, 8'h00);
        step();
        step();
        chk("rstmid_in_read", {mem_read, mem_addr}, {1'b1, 8'h11});
        rst_n = 1'b0;
        #1;
        chk("rstmid_outputs", {busy, done, mem_read, mem_write}, 0);
        chk("rstmid_addr_wdata", {mem_addr, mem_wdata}, 0);
        chk("rstmid_remaining", remaining, 0);
        step();
        step();
        chk("rstmid_no_write", mem[8'h71], 8'h55);
        chk("rstmid_first_word", mem[8'h70], 8'hA1);
        rst_n = 1'b1;
        step();
        go(1'b1, 8'h00, 8'h90, 8'd2, 8'h42);
        run(cyc, wr, bsy);
        chk("post_rst_done_cycle", cyc, 3);
        chk("post_rst_data", {mem[8'h90], mem[8'h91]}, 16'h4242);
        chk("post_rst_remaining", remaining, 0);
        step();

        chk("rw_exclusive", excl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-006 SHALL have port fill_mode  input  1  0 = copy src->dst, 1 = write fill_value to dst.
REQ-007 SHALL have port src_addr  input  ADDR_WIDTH  source start address, copy mode.
REQ-008 SHALL have port dst_addr  input  ADDR_WIDTH  destination start address.
REQ-009 SHALL have port length  input  ADDR_WIDTH  word count; 0 = no transfer.
REQ-010 SHALL have port fill_value  input  DATA_WIDTH  word written in fill mode.
REQ-011 SHALL have port abort  input  1  synchronous cancel of an active transfer.
REQ-012 SHALL have port mem_addr  output  ADDR_WIDTH  drives the memory address.
REQ-013 SHALL have port mem_read  output  1  memory read strobe.
REQ-014 SHALL have port mem_write  output  1  memory write strobe; memory writes at the next clk edge.
REQ-015 SHALL have port mem_wdata  output  DATA_WIDTH  write data to memory.
REQ-016 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data, combinational from mem_addr in the same cycle.
REQ-017 SHALL have port busy  output  1  high while not IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse at transfer completion, not on abort.
REQ-019 SHALL have port remaining  output  ADDR_WIDTH  words not yet written.

Function
REQ-020 SHALL implement the states IDLE, READ, WRITE and DONE.
REQ-021 SHALL, in IDLE on start=1 with length!=0, latch src_addr, dst_addr, length, fill_mode and fill_value; next state is READ in copy mode and WRITE in fill mode.
REQ-022 SHALL, in IDLE on start=1 with length=0, go directly to DONE; no memory access occurs.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL, in READ, drive mem_addr=src pointer and mem_read=1, capture mem_rdata into a holding register at the clock edge, and go to WRITE.
REQ-025 SHALL, in WRITE, drive mem_addr=dst pointer, mem_write=1 and mem_wdata=holding register (copy) or the latched fill value (fill); at the edge, increment both pointers and decrement remaining.
REQ-026 SHALL, after WRITE, go to DONE when remaining was 1; otherwise go to READ (copy) or stay in WRITE (fill).
REQ-027 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE.
REQ-028 SHALL take 2N+1 cycles from the start edge to the done cycle inclusive for a copy of length N, and N+1 cycles for a fill of length N.
REQ-029 SHALL hold mem_read=0 and mem_write=0 in IDLE and DONE; mem_read and mem_write are never both 1.
REQ-030 SHALL wrap pointers modulo 2**ADDR_WIDTH.
REQ-031 SHALL copy strictly in ascending address order; overlapping regions with dst>src propagate already-written data, and this is defined behaviour.
REQ-032 SHALL, on abort=1 in READ or WRITE, suppress mem_write in that cycle and go to IDLE at the next edge with done=0; remaining holds its value until the next start.
REQ-033 SHALL give abort priority over start when both are asserted in the same cycle.

Reset
REQ-034 SHALL, on rst_n=0, immediately enter IDLE and clear the pointers, remaining, the holding register, mem_addr, mem_wdata, mem_read, mem_write, busy and done to 0, regardless of the current state.
REQ-035 SHALL not complete a transfer that is interrupted by reset; no further memory writes occur after reset is asserted.

Structure
REQ-036 SHALL place the state enum (IDLE, READ, WRITE, DONE) in the shared package tinyarch_pkg.
REQ-037 SHALL be a single module with no sub-modules; benches instantiate it together with data_mem.

Verification
REQ-038 SHALL cover copy: mem[0x10..0x13]={A1,B2,C3,D4}, src=0x10, dst=0x40, len=4 -> mem[0x40..0x43]={A1,B2,C3,D4}, done in cycle 9, busy for 8 cycles.
REQ-039 SHALL cover fill: dst=0x80, len=3, fill_value=0x5A -> mem[0x80..0x82]=0x5A, mem[0x83] unchanged, done in cycle 4.
REQ-040 SHALL cover zero length and wrap: len=0 -> done the next cycle with no mem_write; fill dst=0xFE, len=3 -> addresses 0xFE, 0xFF, 0x00 written.
REQ-041 SHALL cover abort: copy len=8, abort during the 3rd WRITE -> exactly 2 words written, done never pulses, remaining=6.
REQ-042 SHALL cover overlap: mem[0x20..0x22]={1,2,3}, src=0x20, dst=0x21, len=2 -> mem[0x21]=1, mem[0x22]=1.
REQ-043 SHALL cover reset mid-transfer: rst_n low during the 2nd READ -> all outputs 0 in the same cycle, no further writes, and a following start operates normally.
